if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch (F) stage of the 5-stage MIPS pipeline. It is the producer side of the IF/ID register:
- Holds the PC and selects the next PC from the decode-stage redirect code PCSrcD.
- Fetches instructions through a req/ack instruction-memory port.
- Presents InstrF/PCPlus4F to the IF/ID register.
- Raises FetchBusy to the hazard unit while an instruction-memory access is outstanding.

Parameters:
RESET_PC, 32'h00003000, PC value loaded on reset
IMEM_BASE, 32'h00003000, lowest legal fetch address (used only with PC_ALIGN_CHECK_EN)
IMEM_BYTES, 4096, size of legal fetch window in bytes (used only with PC_ALIGN_CHECK_EN)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  synchronous, active-high reset
StallF  input  1  hazard unit: hold PC and current instruction
PCSrcD  input  2  next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr
BranchTargetD  input  32  branch target from D
JumpTargetD  input  32  j/jal target from D
JrTargetD  input  32  jr/jalr target (forwarded rs) from D
ImemReq  output  1  instruction memory request
ImemAddr  output  32  instruction memory byte address
ImemAck  input  1  memory response valid; may be high in the same cycle as ImemReq
ImemRdata  input  32  instruction word, valid when ImemAck=1
InstrF  output  32  fetched instruction, to IF/ID
PCPlus4F  output  32  PCF+4, to IF/ID
PCF  output  32  current fetch PC
FetchBusy  output  1  fetch not complete; hazard unit ORs this into StallF/StallD and flushes ID/EX
AdelF  output  1  fetch address error flag (only meaningful with PC_ALIGN_CHECK_EN)

Behaviour:
Reset:
- While Reset=1: PCF<=RESET_PC, state<=REQ, instruction register<=0.
- While Reset=1 the outputs are ImemReq=0, FetchBusy=1, InstrF=0, AdelF=0.
- Reset wins over every other input.
- Reset mid-wait abandons the access. The instruction memory shares Reset, so no stale ack arrives.

FSM, two states:
- REQ:
  - ImemReq=1, ImemAddr=PCF, held stable until ImemAck.
  - ImemAck=0: FetchBusy=1, InstrF=instruction register (don't-care). Stay in REQ; PCF unchanged.
  - ImemAck=1: FetchBusy=0, InstrF=ImemRdata (combinational bypass).
    - StallF=0: PCF<=NextPC, stay in REQ. This gives 1 instr/cycle with zero-wait memory.
    - StallF=1: instruction register<=ImemRdata, go to VALID.
- VALID:
  - ImemReq=0, FetchBusy=0, InstrF=instruction register.
  - StallF=1: hold everything.
  - StallF=0: PCF<=NextPC, go to REQ.

NextPC:
- Selected by PCSrcD: 00 PCF+4, 01 BranchTargetD, 10 JumpTargetD, 11 JrTargetD.
- 32-bit unsigned arithmetic; PCF+4 wraps modulo 2^32.

PC update rule: PCF changes only on a "fetch complete and StallF=0" edge. A redirect is sampled only on that edge.
- The branch-delay slot is architectural: the instruction in F when a branch is in D is always delivered; the target is fetched next.
- PCSrcD must be held by D while StallF=1. The hazard unit guarantees this by stalling D.

Other rules:
- PCPlus4F = PCF+4 at all times (combinational).
- Simultaneous ImemAck and StallF in REQ: data captured, no PC change. No instruction is lost or duplicated.
- ImemAck while not in REQ: ignored.

Optional Feature:
Macro PC_ALIGN_CHECK_EN.
- Defined: a PCF is illegal when PCF[1:0]!=00 or PCF is outside [IMEM_BASE, IMEM_BASE+IMEM_BYTES). For an illegal PCF:
  - No request is issued (ImemReq=0).
  - The fetch completes immediately as if ImemAck=1 with InstrF=32'h0 (nop), and AdelF=1.
  - PC advance follows the normal StallF rules.
  - AdelF is combinational from PCF and reads 0 during Reset.
- Not defined: AdelF tied to 0; ImemAddr = {PCF[31:2],2'b00}; no range check.

Test Plan:
1. Reset 2 cycles, then zero-wait memory (ImemAck=ImemReq), PCSrcD=00, StallF=0 -> ImemAddr 0x3000, 0x3004, 0x3008 on consecutive cycles; FetchBusy=0; PCPlus4F=0x3004, 0x3008, 0x300C.
2. Memory with 2-cycle latency -> FetchBusy=1 for 2 cycles per fetch; ImemAddr stable at 0x3000 until ack; InstrF=ImemRdata on ack cycle; PCF becomes 0x3004 next cycle.
3. Ack at 0x3004 with StallF=1 for 3 cycles -> state VALID; ImemReq=0; InstrF holds captured word; PCF=0x3004 throughout; after StallF falls, next ImemAddr=0x3008 with no refetch of 0x3004.
4. PCSrcD=01, BranchTargetD=0x3100 on a completing edge -> next ImemAddr=0x3100. Then PCSrcD=11, JrTargetD=0x3200 -> 0x3200. Then PCSrcD=10, JumpTargetD=0x3040 -> 0x3040.
5. Reset asserted while waiting for ack at 0x3010 -> first request after release at 0x3000; InstrF=0 and FetchBusy=1 during reset.
6. With PC_ALIGN_CHECK_EN, JrTargetD=0x3002, then 0x4000 -> AdelF=1, InstrF=0, ImemReq=0, FetchBusy=0 for both. Without the macro, 0x3002 -> ImemAddr=0x3000 and AdelF=0.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage is the master; the memory answers with ImemAck/ImemRdata.
interface if_fetch_unit_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemRdata;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemAck,
        input  ImemRdata
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemAck,
        output ImemRdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS fetch stage: PC register, next-PC select, req/ack imem port, IF/ID producer.
// Define PC_ALIGN_CHECK_EN to trap misaligned or out-of-window PCs via AdelF.
module if_fetch_unit #(
`ifdef PC_ALIGN_CHECK_EN
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter int unsigned IMEM_BYTES = 4096,
`endif
    parameter logic [31:0] RESET_PC   = 32'h0000_3000
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               StallF,
    input  logic [1:0]         PCSrcD,
    input  logic [31:0]        BranchTargetD,
    input  logic [31:0]        JumpTargetD,
    input  logic [31:0]        JrTargetD,
    if_fetch_unit_if.master    imem,
    output logic [31:0]        InstrF,
    output logic [31:0]        PCPlus4F,
    output logic [31:0]        PCF,
    output logic               FetchBusy,
    output logic               AdelF
);

    typedef enum logic {
        S_REQ,
        S_VALID
    } state_t;

    state_t      state;
    logic [31:0] instr_q;
    logic [31:0] next_pc;
    logic [31:0] fetch_data;
    logic        pc_bad;
    logic        fetch_done;

    assign PCPlus4F = PCF + 32'd4;

    always_comb begin
        next_pc = PCPlus4F;
        case (PCSrcD)
            2'b01:   next_pc = BranchTargetD;
            2'b10:   next_pc = JumpTargetD;
            2'b11:   next_pc = JrTargetD;
            default: next_pc = PCPlus4F;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic [31:0] pc_off;

    // Offset compare avoids overflow when the window ends at the top of memory
    assign pc_off        = PCF - IMEM_BASE;
    assign pc_bad        = (PCF[1:0] != 2'b00) || (PCF < IMEM_BASE) || (pc_off >= IMEM_BYTES);
    assign imem.ImemAddr = PCF;
`else
    assign pc_bad        = 1'b0;
    assign imem.ImemAddr = {PCF[31:2], 2'b00};
`endif

    // An illegal PC completes at once with a nop instead of touching memory
    assign fetch_done   = (state == S_REQ) && (pc_bad || imem.ImemAck);
    assign fetch_data   = pc_bad ? 32'h0 : imem.ImemRdata;

    assign imem.ImemReq = !Reset && (state == S_REQ) && !pc_bad;
    assign FetchBusy    = Reset || ((state == S_REQ) && !fetch_done);
    assign InstrF       = Reset ? 32'h0 :
                          ((state == S_REQ) && fetch_done) ? fetch_data : instr_q;
    assign AdelF        = !Reset && pc_bad;

    // PC only moves on a completed fetch that the hazard unit lets through
    always_ff @(posedge Clk) begin
        if (Reset) begin
            PCF     <= RESET_PC;
            state   <= S_REQ;
            instr_q <= 32'h0;
        end else begin
            case (state)
                S_REQ: begin
                    if (fetch_done) begin
                        if (StallF) begin
                            instr_q <= fetch_data;
                            state   <= S_VALID;
                        end else begin
                            PCF <= next_pc;
                        end
                    end
                end
                S_VALID: begin
                    if (!StallF) begin
                        PCF   <= next_pc;
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: vector table plus hand-written latency,
// mid-wait reset and PC-check sequences, with an imem handshake scoreboard.
module tb_if_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        StallF = 1'b0;
    logic [1:0]  PCSrcD = 2'b00;
    logic [31:0] BranchTargetD = 32'h0;
    logic [31:0] JumpTargetD = 32'h0;
    logic [31:0] JrTargetD = 32'h0;
    logic [31:0] InstrF;
    logic [31:0] PCPlus4F;
    logic [31:0] PCF;
    logic        FetchBusy;
    logic        AdelF;

    int total = 0;
    int bad = 0;
    int latency = 0;
    int waitCnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic        stall;
        logic [1:0]  src;
        logic [31:0] tgt;
        logic [31:0] expPc;
        logic        expReq;
        logic        expBusy;
        logic [31:0] expInstr;
    } vec_t;
    vec_t vecs[11];

    if_fetch_unit_if bus();

    if_fetch_unit dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .StallF        (StallF),
        .PCSrcD        (PCSrcD),
        .BranchTargetD (BranchTargetD),
        .JumpTargetD   (JumpTargetD),
        .JrTargetD     (JrTargetD),
        .imem          (bus),
        .InstrF        (InstrF),
        .PCPlus4F      (PCPlus4F),
        .PCF           (PCF),
        .FetchBusy     (FetchBusy),
        .AdelF         (AdelF)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Memory model: acks once the request has waited 'latency' cycles
    assign bus.ImemAck   = bus.ImemReq && (waitCnt >= latency);
    assign bus.ImemRdata = memWord(bus.ImemAddr);

    always @(posedge Clk) begin
        if (Reset || !bus.ImemReq || bus.ImemAck) waitCnt <= 0;
        else waitCnt <= waitCnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every completed handshake must match the next expected fetch
    always @(negedge Clk) begin
        sb_t e;
        if (bus.ImemReq && bus.ImemAck) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL sb_unexpected: got addr %h expected no fetch", bus.ImemAddr);
            end else begin
                e = sbq.pop_front();
                checkOutput("sb_addr", bus.ImemAddr, e.addr);
                checkOutput("sb_instr", InstrF, e.data);
            end
        end
    end

    task automatic pushFetch(input logic [31:0] a);
        sb_t e;
        e.addr = a;
        e.data = memWord(a);
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input logic stall, input logic [1:0] src, input logic [31:0] tgt);
        @(posedge Clk);
        #1;
        Reset         = 1'b0;
        StallF        = stall;
        PCSrcD        = src;
        BranchTargetD = (src == 2'b01) ? tgt : 32'h0BAD_0001;
        JumpTargetD   = (src == 2'b10) ? tgt : 32'h0BAD_0002;
        JrTargetD     = (src == 2'b11) ? tgt : 32'h0BAD_0003;
    endtask

    task automatic applyReset(input int cycles);
        @(posedge Clk);
        #1;
        Reset   = 1'b1;
        StallF  = 1'b0;
        PCSrcD  = 2'b00;
        latency = 0;
        repeat (cycles) begin
            @(negedge Clk);
            checkOutput("rst_req", bus.ImemReq, 1'b0);
            checkOutput("rst_busy", FetchBusy, 1'b1);
            checkOutput("rst_instr", InstrF, 32'h0);
            checkOutput("rst_adel", AdelF, 1'b0);
            @(posedge Clk);
            #1;
        end
    endtask

    function automatic vec_t mkVec(input logic stall, input logic [1:0] src, input logic [31:0] tgt,
                                   input logic [31:0] pc, input logic req, input logic busy);
        vec_t v;
        v.stall    = stall;
        v.src      = src;
        v.tgt      = tgt;
        v.expPc    = pc;
        v.expReq   = req;
        v.expBusy  = busy;
        v.expInstr = memWord(pc);
        return v;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Zero-wait memory: streaming, redirects, then a 3-cycle stall
        vecs[0]  = mkVec(1'b0, 2'b00, 32'h0,    32'h3000, 1'b1, 1'b0);
        vecs[1]  = mkVec(1'b0, 2'b00, 32'h0,    32'h3004, 1'b1, 1'b0);
        vecs[2]  = mkVec(1'b0, 2'b01, 32'h3100, 32'h3008, 1'b1, 1'b0);
        vecs[3]  = mkVec(1'b0, 2'b11, 32'h3200, 32'h3100, 1'b1, 1'b0);
        vecs[4]  = mkVec(1'b0, 2'b10, 32'h3040, 32'h3200, 1'b1, 1'b0);
        vecs[5]  = mkVec(1'b0, 2'b00, 32'h0,    32'h3040, 1'b1, 1'b0);
        vecs[6]  = mkVec(1'b1, 2'b00, 32'h0,    32'h3044, 1'b1, 1'b0);
        vecs[7]  = mkVec(1'b1, 2'b00, 32'h0,    32'h3044, 1'b0, 1'b0);
        vecs[8]  = mkVec(1'b1, 2'b00, 32'h0,    32'h3044, 1'b0, 1'b0);
        vecs[9]  = mkVec(1'b0, 2'b00, 32'h0,    32'h3044, 1'b0, 1'b0);
        vecs[10] = mkVec(1'b0, 2'b00, 32'h0,    32'h3048, 1'b1, 1'b0);

        applyReset(2);
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].expReq) pushFetch(vecs[i].expPc);
            applyStimulus(vecs[i].stall, vecs[i].src, vecs[i].tgt);
            @(negedge Clk);
            checkOutput($sformatf("v%0d_pc", i), PCF, vecs[i].expPc);
            checkOutput($sformatf("v%0d_pc4", i), PCPlus4F, vecs[i].expPc + 32'd4);
            checkOutput($sformatf("v%0d_req", i), bus.ImemReq, vecs[i].expReq);
            checkOutput($sformatf("v%0d_busy", i), FetchBusy, vecs[i].expBusy);
            checkOutput($sformatf("v%0d_instr", i), InstrF, vecs[i].expInstr);
            checkOutput($sformatf("v%0d_adel", i), AdelF, 1'b0);
            if (vecs[i].expReq) checkOutput($sformatf("v%0d_addr", i), bus.ImemAddr, vecs[i].expPc);
        end

        // Two-cycle memory latency
        applyReset(1);
        latency = 2;
        pushFetch(32'h3000);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, 2'b00, 32'h0);
            @(negedge Clk);
            checkOutput($sformatf("lat_busy%0d", c), FetchBusy, 1'b1);
            checkOutput($sformatf("lat_addr%0d", c), bus.ImemAddr, 32'h3000);
            checkOutput($sformatf("lat_pc%0d", c), PCF, 32'h3000);
        end
        applyStimulus(1'b0, 2'b00, 32'h0);
        @(negedge Clk);
        checkOutput("lat_ack_busy", FetchBusy, 1'b0);
        checkOutput("lat_ack_instr", InstrF, memWord(32'h3000));
        applyStimulus(1'b0, 2'b00, 32'h0);
        @(negedge Clk);
        checkOutput("lat_next_pc", PCF, 32'h3004);
        checkOutput("lat_next_busy", FetchBusy, 1'b1);

        // Reset while an access at 0x3010 is outstanding
        applyReset(1);
        for (int k = 0; k < 4; k++) begin
            pushFetch(32'h3000 + 32'(4 * k));
            applyStimulus(1'b0, 2'b00, 32'h0);
            @(negedge Clk);
            checkOutput($sformatf("mw_pc%0d", k), PCF, 32'h3000 + 32'(4 * k));
        end
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, 2'b00, 32'h0);
            latency = 5;
            @(negedge Clk);
            checkOutput($sformatf("mw_wait_addr%0d", c), bus.ImemAddr, 32'h3010);
            checkOutput($sformatf("mw_wait_busy%0d", c), FetchBusy, 1'b1);
        end
        applyReset(2);
        pushFetch(32'h3000);
        applyStimulus(1'b0, 2'b00, 32'h0);
        @(negedge Clk);
        checkOutput("mw_restart_req", bus.ImemReq, 1'b1);
        checkOutput("mw_restart_addr", bus.ImemAddr, 32'h3000);
        checkOutput("mw_restart_pc", PCF, 32'h3000);

        // Misaligned / out-of-window jr targets
        applyReset(1);
        pushFetch(32'h3000);
        applyStimulus(1'b0, 2'b11, 32'h3002);
        @(negedge Clk);
        checkOutput("al_first_pc", PCF, 32'h3000);
`ifdef PC_ALIGN_CHECK_EN
        applyStimulus(1'b0, 2'b11, 32'h4000);
        @(negedge Clk);
        checkOutput("al_mis_pc", PCF, 32'h3002);
        checkOutput("al_mis_adel", AdelF, 1'b1);
        checkOutput("al_mis_instr", InstrF, 32'h0);
        checkOutput("al_mis_req", bus.ImemReq, 1'b0);
        checkOutput("al_mis_busy", FetchBusy, 1'b0);
        applyStimulus(1'b0, 2'b00, 32'h0);
        @(negedge Clk);
        checkOutput("al_oor_pc", PCF, 32'h4000);
        checkOutput("al_oor_adel", AdelF, 1'b1);
        checkOutput("al_oor_instr", InstrF, 32'h0);
        checkOutput("al_oor_req", bus.ImemReq, 1'b0);
        checkOutput("al_oor_busy", FetchBusy, 1'b0);
`else
        pushFetch(32'h3000);
        applyStimulus(1'b0, 2'b00, 32'h0);
        @(negedge Clk);
        checkOutput("al_mis_pc", PCF, 32'h3002);
        checkOutput("al_mis_addr", bus.ImemAddr, 32'h3000);
        checkOutput("al_mis_adel", AdelF, 1'b0);
        checkOutput("al_mis_pc4", PCPlus4F, 32'h3006);
        pushFetch(32'h3004);
        applyStimulus(1'b0, 2'b00, 32'h0);
        @(negedge Clk);
        checkOutput("al_next_pc", PCF, 32'h3006);
        checkOutput("al_next_addr", bus.ImemAddr, 32'h3004);
`endif

        @(posedge Clk);
        #1;
        Reset = 1'b1;
        checkOutput("sb_drained", 32'(sbq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
